// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RISC-V multicycle control path: opcodes, ALUOp and
// ALUSrcB encodings, the main-control state enum and the control-word struct.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit to datapath bundle: instruction/handshake inputs and the
// datapath enables. master is the control unit, slave the datapath side.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             illegal;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, state_o, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, state_o, retired
  );
endinterface

// File: rtl/multicycle_out_decode.sv
// Moore output map for the multicycle controller; mem_ready only gates the
// IR/PC load at the end of fetch.
module multicycle_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        // Speculative branch target: oldPC + imm.
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemAddr, StExecI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StExecR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      StAluWb: begin
        ctrl.reg_write = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM with memory-ready stalls, illegal-opcode flag and
// a retired-instruction counter.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal;
  logic             retire;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      StFetch:   if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (bus.opcode)
          OP_LD, OP_SD: state_d = StMemAddr;
          OP_R:         state_d = StExecR;
          OP_ADDI:      state_d = StExecI;
          OP_BEQ:       state_d = StBranch;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAddr: state_d = (bus.opcode == OP_SD) ? StMemWr : StMemRd;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR:   state_d = StAluWb;
      StExecI:   state_d = StAluWb;
      StAluWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:   state_d = StFetch;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  multicycle_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.illegal     = illegal;
  assign bus.state_o     = state_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks R, LD (stalled), BEQ, illegal,
// ADDI and SD sequences, then a reset during a store stall.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_EXECI   = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 7'b0110011;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_memread", 32'(bus.MemRead), 32'd1);
    chk("rst_srcb", 32'(bus.ALUSrcB), 32'd1);
    chk("rst_irwrite", 32'(bus.IRWrite), 32'd1);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);

    // Fetch stall holds state and suppresses IR/PC load
    bus.mem_ready = 1'b0;
    #1;
    chk("fetch_stall_irw", 32'(bus.IRWrite), 32'd0);
    chk("fetch_stall_pcw", 32'(bus.PCWrite), 32'd0);
    step();
    chk("fetch_stall_state", 32'(bus.state_o), 32'(S_FETCH));
    bus.mem_ready = 1'b1;

    // R-type
    step();
    chk("r_decode", 32'(bus.state_o), 32'(S_DECODE));
    chk("r_decode_srcb", 32'(bus.ALUSrcB), 32'd2);
    chk("r_decode_illegal", 32'(bus.illegal), 32'd0);
    step();
    chk("r_exec", 32'(bus.state_o), 32'(S_EXECR));
    chk("r_exec_aluop", 32'(bus.ALUOp), 32'd2);
    chk("r_exec_srca", 32'(bus.ALUSrcA), 32'd1);
    chk("r_exec_srcb", 32'(bus.ALUSrcB), 32'd0);
    chk("r_exec_regw", 32'(bus.RegWrite), 32'd0);
    bus.opcode = 7'b1111111;  // ignored outside DECODE/MEM_ADDR
    step();
    chk("r_wb", 32'(bus.state_o), 32'(S_ALUWB));
    chk("r_wb_regw", 32'(bus.RegWrite), 32'd1);
    chk("r_wb_m2r", 32'(bus.MemtoReg), 32'd0);
    step();
    chk("r_done_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("r_retired", bus.retired, 32'd1);
    chk("r_fetch_regw", 32'(bus.RegWrite), 32'd0);

    // LD with 3 stalled cycles in MEM_RD: 8 cycles total
    bus.opcode = 7'b0000011;
    step();
    step();
    chk("ld_memaddr", 32'(bus.state_o), 32'(S_MEMADDR));
    chk("ld_memaddr_srca", 32'(bus.ALUSrcA), 32'd1);
    chk("ld_memaddr_srcb", 32'(bus.ALUSrcB), 32'd2);
    step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_state", 32'(bus.state_o), 32'(S_MEMRD));
      chk("ld_stall_memread", 32'(bus.MemRead), 32'd1);
      chk("ld_stall_iord", 32'(bus.IorD), 32'd1);
      chk("ld_stall_memwrite", 32'(bus.MemWrite), 32'd0);
      step();
    end
    chk("ld_rd_last", 32'(bus.state_o), 32'(S_MEMRD));
    bus.mem_ready = 1'b1;
    step();
    chk("ld_wb", 32'(bus.state_o), 32'(S_MEMWB));
    chk("ld_wb_m2r", 32'(bus.MemtoReg), 32'd1);
    chk("ld_wb_regw", 32'(bus.RegWrite), 32'd1);
    chk("ld_wb_retired", bus.retired, 32'd1);
    step();
    chk("ld_done_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("ld_retired", bus.retired, 32'd2);

    // BEQ
    bus.opcode = 7'b1100011;
    step();
    step();
    chk("beq_branch", 32'(bus.state_o), 32'(S_BRANCH));
    chk("beq_aluop", 32'(bus.ALUOp), 32'd1);
    chk("beq_pcwc", 32'(bus.PCWriteCond), 32'd1);
    chk("beq_srca", 32'(bus.ALUSrcA), 32'd1);
    step();
    chk("beq_done_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("beq_pcwc_off", 32'(bus.PCWriteCond), 32'd0);
    chk("beq_retired", bus.retired, 32'd3);

    // Unsupported opcode
    bus.opcode = 7'b1111111;
    step();
    chk("ill_decode", 32'(bus.state_o), 32'(S_DECODE));
    chk("ill_pulse", 32'(bus.illegal), 32'd1);
    step();
    chk("ill_next", 32'(bus.state_o), 32'(S_FETCH));
    chk("ill_low", 32'(bus.illegal), 32'd0);
    chk("ill_retired", bus.retired, 32'd3);

    // ADDI
    bus.opcode = 7'b0010011;
    step();
    step();
    chk("addi_exec", 32'(bus.state_o), 32'(S_EXECI));
    chk("addi_srcb", 32'(bus.ALUSrcB), 32'd2);
    chk("addi_aluop", 32'(bus.ALUOp), 32'd0);
    step();
    chk("addi_wb", 32'(bus.state_o), 32'(S_ALUWB));
    step();
    chk("addi_retired", bus.retired, 32'd4);

    // SD completing without stall
    bus.opcode = 7'b0100011;
    step();
    step();
    step();
    chk("sd_memwr", 32'(bus.state_o), 32'(S_MEMWR));
    chk("sd_memwrite", 32'(bus.MemWrite), 32'd1);
    chk("sd_memread", 32'(bus.MemRead), 32'd0);
    step();
    chk("sd_done_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("sd_retired", bus.retired, 32'd5);

    // SD stalled, then reset mid-instruction
    step();
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    chk("sdr_stall", 32'(bus.state_o), 32'(S_MEMWR));
    chk("sdr_retired", bus.retired, 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sdr_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("sdr_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("sdr_rst_retired", bus.retired, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
